// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared widths, PC step and queue entry type for the
//                instruction fetch controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // One fetched instruction together with the byte PC it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue2.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue2
//  Description : 2-entry in-order FIFO of fetch entries with push, pop and
//                flush. Push and pop may occur in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_din,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t r_mem [2];
  logic         r_rd;
  logic         r_wr;
  logic [1:0]   r_count;

  logic         w_pop;
  logic         w_push;

  // A pop on an empty queue or a push into a full one (without a matching
  // pop) is ignored so the pointers can never run away.
  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  // Storage and pointer update; flush drops the contents but keeps the data
  // registers, only the reset clears them so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

endmodule : fetch_queue2
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_ctrl
//  Description : Instruction fetch sequencer. Owns the fetch PC, issues one
//                read per cycle to a 1-cycle registered instruction memory,
//                buffers returned words in a 2-entry queue and presents them
//                to decode over valid/ready. Handles redirects, fetch-enable
//                gating and out-of-range fetch faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              IMEM_DEPTH = 1024
) (
  input  logic               clka,
  input  logic               rsta,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_dout,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [XLEN-1:0]    instr_pc,
  output logic               fetch_fault
);

  localparam logic [XLEN-1:0] c_depth = XLEN'(IMEM_DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_fetch_fault;

  logic            w_fault;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic [2:0]      w_occ;
  logic [1:0]      w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_din;

  // Word index past the end of memory is a fault.
  assign w_fault = ({2'b00, r_fetch_pc[XLEN-1:2]} >= c_depth);

  assign instr_valid = (w_count != 2'd0);
  assign w_pop       = instr_valid & instr_ready;

  // Credit check: queued words plus the read in flight, less whatever leaves
  // this cycle, must leave room for the new read when it returns.
  assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = fetch_en & ~redirect_valid & ~w_fault & (w_occ < 3'd2);

  // Returned data is captured unless a redirect kills it this cycle.
  assign w_push      = r_inflight & ~redirect_valid;
  assign w_din.instr = imem_dout;
  assign w_din.pc    = r_inflight_pc;

  // Fetch PC, in-flight tracking and the sticky fault flag.
  always_ff @(posedge clka) begin
    if (rsta) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_fetch_fault <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (redirect_valid) begin
        r_fetch_pc    <= redirect_pc & ~32'h0000_0003;
        r_fetch_fault <= 1'b0;
      end else begin
        if (w_issue) begin
          r_inflight_pc <= r_fetch_pc;
          r_fetch_pc    <= r_fetch_pc + PC_STEP;
        end
        if (w_fault) begin
          r_fetch_fault <= 1'b1;
        end
      end
    end
  end

  fetch_queue2 u_queue (
    .clk     (clka),
    .rst     (rsta),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign imem_addr   = {2'b00, r_fetch_pc[XLEN-1:2]};
  assign instr_data  = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign fetch_fault = r_fetch_fault;

endmodule : instr_fetch_ctrl
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_ctrl
//  Description : Directed, table-driven bench for instr_fetch_ctrl. Two
//                instances share stimulus: one at the default depth (stream,
//                backpressure, redirect, enable gating, reset) and one with
//                a 4-word memory for the fault sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

  localparam logic [31:0] c_base = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rv;
  logic [31:0] rpc;
  logic        rdy;

  logic [31:0] addr_a, dout_a, data_a, pc_a;
  logic        valid_a, fault_a;
  logic [31:0] addr_b, dout_b, data_b, pc_b;
  logic        valid_b, fault_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory models: word i holds A000_0000 + i, 1-cycle read.
  always @(posedge clk) begin
    if (rst) dout_a <= 32'h0;
    else     dout_a <= c_base + addr_a;
  end

  always @(posedge clk) begin
    if (rst) dout_b <= 32'h0;
    else     dout_b <= c_base + addr_b;
  end

  instr_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_DEPTH(1024)) dut_a (
    .clka           (clk),
    .rsta           (rst),
    .fetch_en       (en),
    .redirect_valid (rv),
    .redirect_pc    (rpc),
    .imem_addr      (addr_a),
    .imem_dout      (dout_a),
    .instr_valid    (valid_a),
    .instr_ready    (rdy),
    .instr_data     (data_a),
    .instr_pc       (pc_a),
    .fetch_fault    (fault_a)
  );

  instr_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_DEPTH(4)) dut_b (
    .clka           (clk),
    .rsta           (rst),
    .fetch_en       (en),
    .redirect_valid (rv),
    .redirect_pc    (rpc),
    .imem_addr      (addr_b),
    .imem_dout      (dout_b),
    .instr_valid    (valid_b),
    .instr_ready    (rdy),
    .instr_data     (data_b),
    .instr_pc       (pc_b),
    .fetch_fault    (fault_b)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic        dp;
    logic [31:0] epc;
    logic [31:0] edata;
    logic [31:0] eaddr;
  } vec_t;

  localparam int c_nvec = 38;
  vec_t vecs [c_nvec];

  function automatic vec_t mk(input logic r, input logic e, input logic v,
                              input logic [31:0] p, input logic y,
                              input logic xv, input logic xdp,
                              input logic [31:0] xpc, input logic [31:0] xd,
                              input logic [31:0] xa);
    vec_t t;
    t.rst = r; t.en = e; t.rv = v; t.rpc = p; t.rdy = y;
    t.ev = xv; t.dp = xdp; t.epc = xpc; t.edata = xd; t.eaddr = xa;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge; outputs seen right after
  // belong to the same cycle since they all come from registers.
  task automatic drive(input logic r, input logic e, input logic v,
                       input logic [31:0] p, input logic y);
    @(negedge clk);
    rst = r; en = e; rv = v; rpc = p; rdy = y;
  endtask

  initial begin
    // -------- vector table (cycle 0 = first cycle after reset) --------
    vecs[0] = mk(0, 1, 0, 0, 1, 0, 1, 32'h0, 32'h0, 32'h0);
    vecs[1] = mk(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h1);
    for (int k = 2; k <= 5; k++)
      vecs[k] = mk(0, 1, 0, 0, 1, 1, 1, 32'(4*(k-2)), c_base + 32'(k-2), 32'(k));
    // decode stalls: head holds pc 0x10, issue stops at word 6
    for (int k = 6; k <= 10; k++)
      vecs[k] = mk(0, 1, 0, 0, 0, 1, 1, 32'h10, c_base + 32'h4, 32'h6);
    for (int k = 11; k <= 16; k++)
      vecs[k] = mk(0, 1, 0, 0, 1, 1, 1, 32'(4*(k-7)), c_base + 32'(k-7), 32'(k-5));
    // redirect to 0x43 with one word queued and one read in flight
    vecs[17] = mk(0, 1, 1, 32'h43, 0, 1, 1, 32'h28, c_base + 32'hA, 32'hC);
    vecs[18] = mk(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h10);
    vecs[19] = mk(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h11);
    for (int k = 20; k <= 22; k++)
      vecs[k] = mk(0, 1, 0, 0, 1, 1, 1, 32'h40 + 32'(4*(k-20)), c_base + 32'h10 + 32'(k-20),
                   32'h12 + 32'(k-20));
    // fetch_en pattern 1,0,0,1,1,0,0,1,1,1
    vecs[23] = mk(0, 1, 0, 0, 1, 1, 1, 32'h4C, c_base + 32'h13, 32'h15);
    vecs[24] = mk(0, 0, 0, 0, 1, 1, 1, 32'h50, c_base + 32'h14, 32'h16);
    vecs[25] = mk(0, 0, 0, 0, 1, 1, 1, 32'h54, c_base + 32'h15, 32'h16);
    vecs[26] = mk(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h16);
    vecs[27] = mk(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h17);
    vecs[28] = mk(0, 0, 0, 0, 1, 1, 1, 32'h58, c_base + 32'h16, 32'h18);
    vecs[29] = mk(0, 0, 0, 0, 1, 1, 1, 32'h5C, c_base + 32'h17, 32'h18);
    vecs[30] = mk(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h18);
    vecs[31] = mk(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h19);
    vecs[32] = mk(0, 1, 0, 0, 1, 1, 1, 32'h60, c_base + 32'h18, 32'h1A);
    // reset mid-stream, then restart from RESET_PC
    vecs[33] = mk(1, 1, 0, 0, 1, 1, 1, 32'h64, c_base + 32'h19, 32'h1B);
    vecs[34] = mk(0, 1, 0, 0, 1, 0, 1, 32'h0, 32'h0, 32'h0);
    vecs[35] = mk(0, 1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h1);
    vecs[36] = mk(0, 1, 0, 0, 1, 1, 1, 32'h0, c_base, 32'h2);
    vecs[37] = mk(0, 1, 0, 0, 1, 1, 1, 32'h4, c_base + 32'h1, 32'h3);

    rst = 1'b1; en = 1'b0; rv = 1'b0; rpc = 32'h0; rdy = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < c_nvec; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      chk($sformatf("vec%0d valid", i), {31'h0, valid_a}, {31'h0, vecs[i].ev});
      chk($sformatf("vec%0d addr", i), addr_a, vecs[i].eaddr);
      chk($sformatf("vec%0d fault", i), {31'h0, fault_a}, 32'h0);
      if (vecs[i].dp) begin
        chk($sformatf("vec%0d pc", i), pc_a, vecs[i].epc);
        chk($sformatf("vec%0d data", i), data_a, vecs[i].edata);
      end
    end

    // -------- back-to-back redirects: the last one wins --------
    drive(0, 1, 1, 32'h100, 1);
    drive(0, 1, 1, 32'h204, 1);
    chk("b2b flushed valid", {31'h0, valid_a}, 32'h0);
    chk("b2b first target addr", addr_a, 32'h40);
    drive(0, 1, 0, 0, 1);
    chk("b2b r+1 valid", {31'h0, valid_a}, 32'h0);
    chk("b2b r+1 addr", addr_a, 32'h81);
    drive(0, 1, 0, 0, 1);
    chk("b2b r+2 valid", {31'h0, valid_a}, 32'h0);
    drive(0, 1, 0, 0, 1);
    chk("b2b r+3 valid", {31'h0, valid_a}, 32'h1);
    chk("b2b r+3 pc", pc_a, 32'h204);
    chk("b2b r+3 data", data_a, c_base + 32'h81);

    // -------- fault sequence on the 4-word instance --------
    drive(1, 1, 0, 0, 1);
    for (int k = 0; k <= 12; k++) begin
      drive(0, 1, (k == 9) ? 1'b1 : 1'b0, 32'h0, 1);
      if (k >= 2 && k <= 5) begin
        chk($sformatf("flt%0d valid", k), {31'h0, valid_b}, 32'h1);
        chk($sformatf("flt%0d pc", k), pc_b, 32'(4*(k-2)));
        chk($sformatf("flt%0d data", k), data_b, c_base + 32'(k-2));
      end else if (k == 12) begin
        chk("flt12 valid", {31'h0, valid_b}, 32'h1);
        chk("flt12 pc", pc_b, 32'h0);
        chk("flt12 data", data_b, c_base);
      end else begin
        chk($sformatf("flt%0d valid", k), {31'h0, valid_b}, 32'h0);
      end
      chk($sformatf("flt%0d fault", k), {31'h0, fault_b},
          (k >= 5 && k <= 9) ? 32'h1 : 32'h0);
      if (k <= 3)               chk($sformatf("flt%0d addr", k), addr_b, 32'(k));
      else if (k <= 9)          chk($sformatf("flt%0d addr", k), addr_b, 32'h4);
      else                      chk($sformatf("flt%0d addr", k), addr_b, 32'(k-10));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instr_fetch_ctrl
`default_nettype wire
